// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus arbiter with per-host lock, bounded lock
// hold and a transaction timeout that forces the bus to be released.
module bus_rr_arbiter #(
    parameter int NrHosts = 4,
    parameter int MaxHold = 4,
    parameter int Timeout = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NrHosts-1:0]         req_i,
    input  logic [NrHosts-1:0]         lock_i,
    input  logic                       done_i,
    output logic [NrHosts-1:0]         gnt_o,
    output logic [$clog2(NrHosts)-1:0] sel_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int SelW = $clog2(NrHosts);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state_q;
    logic [SelW-1:0]     sel_q;
    logic [SelW-1:0]     last_q;
    logic [NrHosts-1:0]  gnt_q;
    logic [7:0]          hold_cnt;
    logic [7:0]          wait_cnt;
    logic                timeout_q;

    logic [SelW-1:0]     arb_base;
    logic [SelW-1:0]     next_sel;
    logic [NrHosts-1:0]  next_gnt;
    logic                retain;
    logic                abort;
    logic                timed_out;
    logic                release_now;

    // First requester strictly after 'base', wrapping around; the loop runs
    // from the farthest offset down so the nearest requester wins.
    function automatic logic [SelW-1:0] next_host(
        input logic [SelW-1:0]    base,
        input logic [NrHosts-1:0] req
    );
        logic [SelW-1:0] result;
        int              idx;
        result = base;
        for (int i = NrHosts; i >= 1; i--) begin
            idx = (int'(base) + i) % NrHosts;
            if (req[idx]) begin
                result = SelW'(idx);
            end
        end
        return result;
    endfunction

    // Arbitration and release decisions; in BUSY the current host acts as 'last'
    // so a release and the next grant happen in the same cycle.
    always_comb begin
        arb_base    = (state_q == IDLE) ? last_q : sel_q;
        next_sel    = next_host(arb_base, req_i);
        next_gnt    = {{(NrHosts-1){1'b0}}, 1'b1} << next_sel;
        retain      = done_i && lock_i[sel_q] && req_i[sel_q]
                      && (hold_cnt < 8'(MaxHold - 1));
        abort       = !done_i && !req_i[sel_q];
        timed_out   = !done_i && req_i[sel_q] && (wait_cnt == 8'(Timeout - 1));
        release_now = !retain && (done_i || abort || timed_out);
    end

    // Arbiter FSM with registered grant, select and timeout pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= SelW'(NrHosts - 1);
            gnt_q     <= '0;
            hold_cnt  <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q  <= BUSY;
                        sel_q    <= next_sel;
                        gnt_q    <= next_gnt;
                        hold_cnt <= '0;
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (retain) begin
                        hold_cnt <= hold_cnt + 8'd1;
                        wait_cnt <= '0;
                    end else if (release_now) begin
                        timeout_q <= timed_out;
                        last_q    <= sel_q;
                        hold_cnt  <= '0;
                        wait_cnt  <= '0;
                        if (|req_i) begin
                            sel_q <= next_sel;
                            gnt_q <= next_gnt;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign sel_o     = sel_q;
    assign busy_o    = (state_q == BUSY);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed test of the round-robin arbiter with
// hand-computed grant sequences, lock hold limit, timeout and reset.
module tb_bus_rr_arbiter;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b1;
    logic [3:0] req_i  = '0;
    logic [3:0] lock_i = '0;
    logic       done_i = 1'b0;
    logic [3:0] gnt_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       timeout_o;

    int checkCount = 0;
    int errorCount = 0;

    bus_rr_arbiter #(
        .NrHosts(4),
        .MaxHold(4),
        .Timeout(16)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .lock_i   (lock_i),
        .done_i   (done_i),
        .gnt_o    (gnt_o),
        .sel_o    (sel_o),
        .busy_o   (busy_o),
        .timeout_o(timeout_o)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock, input logic done);
        req_i  = req;
        lock_i = lock;
        done_i = done;
    endtask

    task automatic waitCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        waitCycle();
        rst_ni = 1'b1;
    endtask

    // Directed scenarios, each starting from a fresh reset.
    initial begin
        // Reset values before any clock edge.
        #1 rst_ni = 1'b0;
        #2;
        checkOutput("rst_gnt", gnt_o, 4'b0000);
        checkOutput("rst_sel", sel_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_timeout", timeout_o, 0);
        waitCycle();
        rst_ni = 1'b1;

        // All four hosts requesting, done every second cycle.
        $display("[TB] scenario: full rotation");
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        waitCycle();
        checkOutput("s1_first_sel", sel_o, 0);
        checkOutput("s1_first_gnt", gnt_o, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(4'b1111, 4'b0000, 1'b0);
            waitCycle();
            checkOutput("s1_hold_sel", sel_o, k - 1);
            applyStimulus(4'b1111, 4'b0000, 1'b1);
            waitCycle();
            checkOutput("s1_next_sel", sel_o, k % 4);
            checkOutput("s1_next_gnt", gnt_o, 32'd1 << (k % 4));
            checkOutput("s1_next_busy", busy_o, 1);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        waitCycle();
        checkOutput("s1_idle_busy", busy_o, 0);
        checkOutput("s1_idle_gnt", gnt_o, 4'b0000);

        // Hosts 0 and 2 alternating, then idle behaviour and abort.
        $display("[TB] scenario: sparse requests");
        doReset();
        applyStimulus(4'b0101, 4'b0000, 1'b0);
        waitCycle();
        checkOutput("s2_gnt0", gnt_o, 4'b0001);
        applyStimulus(4'b0101, 4'b0000, 1'b1);
        waitCycle();
        checkOutput("s2_gnt1", gnt_o, 4'b0100);
        checkOutput("s2_sel1", sel_o, 2);
        waitCycle();
        checkOutput("s2_gnt2", gnt_o, 4'b0001);
        waitCycle();
        checkOutput("s2_gnt3", gnt_o, 4'b0100);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        waitCycle();
        checkOutput("s2_idle_busy", busy_o, 0);
        checkOutput("s2_idle_gnt", gnt_o, 4'b0000);
        checkOutput("s2_idle_sel", sel_o, 2);
        waitCycle();
        checkOutput("s2_idle_done_busy", busy_o, 0);
        checkOutput("s2_idle_sel_hold", sel_o, 2);
        applyStimulus(4'b1001, 4'b0000, 1'b0);
        waitCycle();
        checkOutput("s2_wrap_gnt", gnt_o, 4'b1000);
        checkOutput("s2_wrap_sel", sel_o, 3);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        waitCycle();
        checkOutput("s2_abort_busy", busy_o, 0);
        checkOutput("s2_abort_timeout", timeout_o, 0);

        // Host 2 alone with lock: hold limit forces a re-grant.
        $display("[TB] scenario: lock hold limit");
        doReset();
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        waitCycle();
        checkOutput("s3_gnt", gnt_o, 4'b0100);
        for (int n = 1; n <= 6; n++) begin
            applyStimulus(4'b0100, 4'b0100, 1'b1);
            waitCycle();
            checkOutput("s3_lock_gnt", gnt_o, 4'b0100);
            checkOutput("s3_lock_timeout", timeout_o, 0);
            if (n == 4) begin
                checkOutput("s3_hold_cleared", dut.hold_cnt, 0);
            end
        end
        applyStimulus(4'b0101, 4'b0100, 1'b1);
        waitCycle();
        checkOutput("s3_retain_gnt", gnt_o, 4'b0100);
        waitCycle();
        checkOutput("s3_rotate_gnt", gnt_o, 4'b0001);

        // Host 1 never completes: timeout 16 cycles after grant.
        $display("[TB] scenario: timeout");
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        waitCycle();
        checkOutput("s4_gnt", gnt_o, 4'b0010);
        for (int c = 1; c <= 16; c++) begin
            waitCycle();
            checkOutput("s4_timeout", timeout_o, (c == 16) ? 1 : 0);
        end
        checkOutput("s4_regrant_gnt", gnt_o, 4'b0010);
        checkOutput("s4_regrant_busy", busy_o, 1);
        waitCycle();
        checkOutput("s4_pulse_end", timeout_o, 0);

        // Done arriving in the timeout cycle wins over the timeout.
        $display("[TB] scenario: done at timeout");
        doReset();
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        waitCycle();
        for (int c = 1; c <= 15; c++) begin
            waitCycle();
        end
        checkOutput("s5_pre_timeout", timeout_o, 0);
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        waitCycle();
        checkOutput("s5_done_timeout", timeout_o, 0);
        checkOutput("s5_done_gnt", gnt_o, 4'b0010);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            waitCycle();
        end
        checkOutput("s5_wait_cleared", timeout_o, 0);
        waitCycle();
        checkOutput("s5_late_timeout", timeout_o, 1);

        // Reset pulse in the middle of a transaction.
        $display("[TB] scenario: reset mid-busy");
        doReset();
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        waitCycle();
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        waitCycle();
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        waitCycle();
        checkOutput("s6_pre_sel", sel_o, 1);
        rst_ni = 1'b0;
        #1;
        checkOutput("s6_async_gnt", gnt_o, 4'b0000);
        checkOutput("s6_async_busy", busy_o, 0);
        checkOutput("s6_async_sel", sel_o, 0);
        checkOutput("s6_async_timeout", timeout_o, 0);
        waitCycle();
        rst_ni = 1'b1;
        checkOutput("s6_rst_gnt", gnt_o, 4'b0000);
        waitCycle();
        checkOutput("s6_first_gnt", gnt_o, 4'b0001);
        checkOutput("s6_first_sel", sel_o, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
